gray_adder_arbiter: RTL
=======================

# gray_adder_arbiter

Round-robin arbiter and sequencer that shares one `gray_code_adder` instance among `NREQ` requesters. Each requester presents a pair of Gray-coded operands and a carry-in on a valid/ready handshake. The block grants one requester at a time, registers the operands, computes the Gray-coded sum and carry-out, and returns the result tagged with the requester ID on a valid/ready response port. It sits between several Gray-domain clients and the single shared adder datapath.

## Interface
- `WIDTH`, default 4: operand/sum width in bits (Gray coded).
- `NREQ`, default 4: number of requesters, ≥2, need not be a power of two.
- `IDW`, derived: `$clog2(NREQ)`; ID width.

Ports:
- `clk` input, 1: single clock; all state on rising edge.
- `rst_n` input, 1: reset, asynchronous, active-low.
- `req_valid` input, [NREQ]: requester i has an operation pending.
- `req_a` input, [NREQ][WIDTH]: Gray operand a per requester.
- `req_b` input, [NREQ][WIDTH]: Gray operand b per requester.
- `req_ci` input, [NREQ]: carry-in per requester.
- `req_ready` output, [NREQ]: one-hot grant; handshake with requester i when `req_valid[i] && req_ready[i]`.
- `rsp_valid` output, 1: result available.
- `rsp_ready` input, 1: consumer accepts result.
- `rsp_id` output, IDW: index of the requester that owns the result.
- `rsp_sum` output, WIDTH: Gray-coded sum.
- `rsp_co` output, 1: binary carry-out.

## Operation
- **FSM states:** IDLE, CALC, RESP.
- **IDLE**
  - Winner = first index i in order ptr, ptr+1, …, NREQ-1, 0, … with `req_valid[i]`=1.
  - `req_ready[winner]`=1 combinationally; all other `req_ready` bits are 0.
  - On the handshake: capture a/b/ci/winner into operand registers, set ptr ← (winner+1) mod NREQ, go to CALC.
  - With no valid request, stay in IDLE with `req_ready`=0.
- **CALC**
  - Registered operands drive the shared adder.
  - Register the result: sum = bin2gray((gray2bin(a)+gray2bin(b)+ci) mod 2^WIDTH), co = bit WIDTH of the binary sum.
  - Go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_id`/`rsp_sum`/`rsp_co` stay stable until `rsp_ready`.
  - On `rsp_ready`, go to IDLE.
  - `req_ready`=0 throughout.
- **Requester rules:** `req_a`/`req_b`/`req_ci` must stay stable while `req_valid` is high and not yet granted. Requesters may deassert `req_valid` before grant, and the block must tolerate this. `req_valid` changes never affect a captured operation.
- **Simultaneous requests:** resolved only by ptr; no fixed priority.
- **ptr wrap:** after winner NREQ-1, ptr=0, including non-power-of-two NREQ. ptr never takes values ≥ NREQ.
- **Reset (any state, including mid-CALC/RESP):**
  - State=IDLE, ptr=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_co`=0, operand registers 0.
  - `req_ready`=0 while `rst_n` is low.
  - The in-flight operation is discarded, with no response.

## Timing
- Grant handshake in cycle T (IDLE) → CALC in T+1 → `rsp_valid` high from T+2.
- Minimum issue interval is 3 cycles, and 4 if the response is accepted in the cycle after `rsp_valid` rises. The next grant occurs in the cycle after the response handshake.
- `req_ready` depends combinationally on `req_valid` and ptr only. All `rsp_*` outputs are registered.
- Backpressure: `rsp_ready` low holds RESP indefinitely, with no grants issued.

## Structure
- **Shared package `gray_pkg`:** state enum typedef (`IDLE`, `CALC`, `RESP`) and an ID-width helper function.
- **Shared adder:** existing `gray_code_adder` instantiated once with `.WIDTH(WIDTH)`. `ci` comes from the operand register; `sum`/`co` feed the result registers.
- **Sub-module `rr_pick`:** combinational round-robin selector. Inputs `req_valid[NREQ]` and ptr; outputs a one-hot grant, a found flag, and the winner index.

## Test plan
- **Single add:** WIDTH=4, requester 2 sends a=4'b0011, b=4'b0010, ci=0 (2+3) → grant T, `rsp_valid` at T+2, `rsp_id`=2, `rsp_sum`=4'b0111, `rsp_co`=0.
- **Overflow:** a=4'b1000 (15), b=4'b0000, ci=1 → `rsp_sum`=4'b0000, `rsp_co`=1.
- **Fairness:** all 4 requesters hold `req_valid` continuously with `rsp_ready`=1 → grant order 0,1,2,3,0,1; each `rsp_id` matches its grant.
- **Backpressure:** `rsp_ready`=0 for 5 cycles in RESP → `rsp_*` outputs unchanged, `req_ready`=0 throughout; accepted on the sixth cycle, next grant the cycle after.
- **Reset mid-operation:** assert `rst_n`=0 during CALC → all outputs 0 immediately (asynchronous), no response after release, and the first grant after reset goes to requester 0 when all are requesting.
- **NREQ=3 wrap:** only requesters 2 and 0 requesting → grants alternate 2,0,2; ptr never exceeds 2.

Source files
------------

// File: rtl/gray_pkg.sv
// gray_pkg: FSM state type and ID-width helper shared by the Gray adder arbiter.
package gray_pkg;

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gray_adder_arbiter_if.sv
// gray_adder_arbiter_if: requester and response bundle of the shared Gray adder.
interface gray_adder_arbiter_if import gray_pkg::*; #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4,
   parameter int IDW   = id_width(NREQ)
);

   logic [NREQ-1:0]            req_valid;
   logic [NREQ-1:0][WIDTH-1:0] req_a;
   logic [NREQ-1:0][WIDTH-1:0] req_b;
   logic [NREQ-1:0]            req_ci;
   logic [NREQ-1:0]            req_ready;
   logic                       rsp_valid;
   logic                       rsp_ready;
   logic [IDW-1:0]             rsp_id;
   logic [WIDTH-1:0]           rsp_sum;
   logic                       rsp_co;

   modport master (
      output req_valid, req_a, req_b, req_ci, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_co
   );

   modport slave (
      input  req_valid, req_a, req_b, req_ci, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_co
   );

endinterface

// File: rtl/gray_adder_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first valid index at or after ptr.
module rr_pick import gray_pkg::*; #(
   parameter int NREQ = 4,
   parameter int IDW  = id_width(NREQ)
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic            found,
   output logic [IDW-1:0]  idx
);

   // Scan from the farthest candidate back to ptr so the nearest one wins.
   always_comb begin
      int j;
      logic [IDW-1:0] c;
      j = 0;
      c = '0;
      found = 1'b0;
      idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         c = IDW'((j >= NREQ) ? j - NREQ : j);
         if (valid[c]) begin
            found = 1'b1;
            idx = c;
         end
      end
   end

   assign grant = found ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/gray_code_adder.sv
// gray_code_adder: combinational adder of two Gray-coded operands with binary carry in/out.
module gray_code_adder #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic [WIDTH-1:0] sum,
   output logic             co
);

   logic [WIDTH-1:0] ab;
   logic [WIDTH-1:0] bb;
   logic [WIDTH:0]   s;

   // Binary bit i is the XOR of all Gray bits at or above i.
   always_comb begin
      ab = '0;
      bb = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ab[i] = ^(a >> i);
         bb[i] = ^(b >> i);
      end
   end

   assign s   = {1'b0, ab} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
   assign sum = s[WIDTH-1:0] ^ (s[WIDTH-1:0] >> 1);
   assign co  = s[WIDTH];

endmodule

// File: rtl/gray_adder_arbiter.sv
// gray_adder_arbiter: round-robin sharing of one Gray adder among NREQ requesters,
// with registered operands and a tagged valid/ready response.
module gray_adder_arbiter import gray_pkg::*; #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4,
   parameter int IDW   = id_width(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   gray_adder_arbiter_if.slave  bus
);

   state_t           state;
   state_t           nxt;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   win;
   logic [IDW-1:0]   op_id;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] sum;
   logic             op_ci;
   logic             co;
   logic             found;
   logic [NREQ-1:0]  grant;

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .valid (bus.req_valid),
      .ptr   (ptr),
      .grant (grant),
      .found (found),
      .idx   (win)
   );

   gray_code_adder #(.WIDTH(WIDTH)) u_add (
      .a   (op_a),
      .b   (op_b),
      .ci  (op_ci),
      .sum (sum),
      .co  (co)
   );

   // A visible grant is always a handshake, since it only lights a valid requester.
   always_comb begin
      nxt = (state == IDLE && found) ? CALC :
            (state == CALC) ? RESP :
            (state == RESP && bus.rsp_ready) ? IDLE : state;
      bus.req_ready = (rst_n && state == IDLE) ? grant : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         ptr           <= '0;
         op_a          <= '0;
         op_b          <= '0;
         op_ci         <= 1'b0;
         op_id         <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_id    <= '0;
         bus.rsp_sum   <= '0;
         bus.rsp_co    <= 1'b0;
      end else begin
         state <= nxt;
         if (state == IDLE && found) begin
            op_a  <= bus.req_a[win];
            op_b  <= bus.req_b[win];
            op_ci <= bus.req_ci[win];
            op_id <= win;
            ptr   <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
         end
         if (state == CALC) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= op_id;
            bus.rsp_sum   <= sum;
            bus.rsp_co    <= co;
         end
         if (state == RESP && bus.rsp_ready) bus.rsp_valid <= 1'b0;
      end
   end

endmodule
